// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared core definitions for the register-file write-port arbiter:
//   - arb_state_t       : arbiter FSM state encoding (NORMAL / FORCE_LLU)
//   - WB_DATA_WIDTH     : default register data width
//   - WB_ADDR_WIDTH     : default register index width
//   - WB_STARVE_CNT_W   : width of the LLU starve counter (covers limits 1..15)
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_ADDR_WIDTH   = 5;
    localparam int WB_STARVE_CNT_W = 4;

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_LLU = 1'b1
    } arb_state_t;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Arbitrates the single register-file write port between the MEM/WB pipe
// stage and the long-latency unit (mul/div). The pipe normally wins; a
// waiting LLU result is granted whenever the pipe has nothing to write.
//
// Optional feature (macro WB_ARB_STARVE_EN): a starve counter tracks how many
// cycles a pending LLU result has been refused. When it reaches STARVE_LIMIT
// the arbiter enters FORCE_LLU for one cycle, stalls the pipe and writes the
// LLU result. Without the macro the pipe has strict priority and pipe_stall
// is tied low.
//
// Parameters:
//   DATA_WIDTH   register data width
//   ADDR_WIDTH   register index width
//   STARVE_LIMIT cycles an LLU request may be refused before the pipe is
//                stalled (1..15, used only with WB_ARB_STARVE_EN)
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   pipe_valid/rd/data     MEM/WB write-back request
//   pipe_stall             freeze the pipe (combinational)
//   llu_valid/rd/data      LLU write-back request, held until accepted
//   llu_ready              LLU granted this cycle (combinational)
//   rf_we/waddr/wdata      registered register-file write port
//   grant_llu              registered; current rf_* write came from the LLU
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  pipe_valid,
    input  logic [ADDR_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  pipe_stall,

    input  logic                  llu_valid,
    input  logic [ADDR_WIDTH-1:0] llu_rd,
    input  logic [DATA_WIDTH-1:0] llu_data,
    output logic                  llu_ready,

    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  grant_llu
);

    arb_state_t state;
    logic       in_force;
    logic       gnt_pipe;
    logic       gnt_llu;

    assign in_force = (state == FORCE_LLU);

    // Grant decision. Reset suppresses every grant so nothing is handshaken
    // while the block is being cleared (including an aborted FORCE_LLU).
    always_comb begin
        gnt_pipe = 1'b0;
        gnt_llu  = 1'b0;
        if (!rst) begin
            if (in_force) begin
                gnt_llu = llu_valid;
            end else if (pipe_valid) begin
                gnt_pipe = 1'b1;
            end else begin
                gnt_llu = llu_valid;
            end
        end
    end

    assign llu_ready  = gnt_llu;
    assign pipe_stall = in_force && !rst;

`ifdef WB_ARB_STARVE_EN
    localparam logic [WB_STARVE_CNT_W-1:0] LIMIT   = WB_STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [WB_STARVE_CNT_W-1:0] CNT_ONE = WB_STARVE_CNT_W'(1);

    logic [WB_STARVE_CNT_W-1:0] starve_cnt;
    logic [WB_STARVE_CNT_W-1:0] starve_cnt_nxt;

    // Counts consecutive refused cycles of a pending LLU result; any accept
    // or withdrawal of the request starts the count over.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!llu_valid || gnt_llu) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt_nxt = starve_cnt + CNT_ONE;
        end
    end

    // FORCE_LLU always lasts a single cycle: either the LLU is granted
    // (valid high) or the request vanished, and both cases return to NORMAL.
    // The pipe request held under stall is then granted in that NORMAL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            case (state)
                NORMAL: begin
                    if (starve_cnt_nxt == LIMIT) begin
                        state <= FORCE_LLU;
                    end
                end
                FORCE_LLU: begin
                    state <= NORMAL;
                end
                default: begin
                    state <= NORMAL;
                end
            endcase
        end
    end
`else
    // Strict pipe priority: no starve tracking, the FSM never leaves NORMAL.
    assign state = NORMAL;

    // STARVE_LIMIT only shapes the starve logic, which is not built here.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // Registered write port. Address/data only move on a grant; a write to
    // register 0 completes its handshake but never asserts rf_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_llu <= 1'b0;
        end else begin
            rf_we     <= 1'b0;
            grant_llu <= 1'b0;
            if (gnt_pipe) begin
                rf_we    <= (pipe_rd != '0);
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (gnt_llu) begin
                rf_we     <= (llu_rd != '0);
                rf_waddr  <= llu_rd;
                rf_wdata  <= llu_data;
                grant_llu <= 1'b1;
            end
        end
    end

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Self-checking bench for wb_port_arbiter (default parameters). Inputs are
// driven on the falling edge; combinational outputs are checked 1 ns later
// and the expected registered write is queued, then popped and compared
// 1 ns after the next rising edge. Starvation expectations depend on
// whether WB_ARB_STARVE_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        grant_llu;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_valid(pipe_valid),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .pipe_stall(pipe_stall),
        .llu_valid (llu_valid),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .llu_ready (llu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_llu (grant_llu)
    );

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        rdy;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        gnt;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        gnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic rdy, input logic we, input logic [4:0] addr,
                                input logic [31:0] data, input logic gnt);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pd = pd;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.rdy = rdy; v.we = we; v.addr = addr; v.data = data; v.gnt = gnt;
        return v;
    endfunction

    // One arbitration cycle: drive, check combinational outputs, queue the
    // expected write, then pop and compare it after the rising edge.
    task automatic cycle(input string nm, input vec_t v, input logic e_stall);
        exp_t e;
        exp_t got;
        @(negedge clk);
        pipe_valid = v.pv; pipe_rd = v.prd; pipe_data = v.pd;
        llu_valid  = v.lv; llu_rd  = v.lrd; llu_data  = v.ld;
        #1;
        chk({nm, "_llu_ready"}, llu_ready, v.rdy);
        chk({nm, "_pipe_stall"}, pipe_stall, e_stall);
        e.we = v.we; e.addr = v.addr; e.data = v.data; e.gnt = v.gnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, "_scoreboard_empty"}, 1, 0);
        end else begin
            got = sb.pop_front();
            chk({nm, "_rf_we"}, rf_we, got.we);
            chk({nm, "_grant_llu"}, grant_llu, got.gnt);
            if (got.we) begin
                chk({nm, "_rf_waddr"}, rf_waddr, got.addr);
                chk({nm, "_rf_wdata"}, rf_wdata, got.data);
            end
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_rf_we"}, rf_we, 0);
        chk({nm, "_rf_waddr"}, rf_waddr, 0);
        chk({nm, "_rf_wdata"}, rf_wdata, 0);
        chk({nm, "_grant_llu"}, grant_llu, 0);
        chk({nm, "_pipe_stall"}, pipe_stall, 0);
        chk({nm, "_llu_ready"}, llu_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic fc;

        // Table: no more than three consecutive refused LLU cycles, so the
        // starve counter never reaches its limit here in either build.
        vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 1, 5'd5,  32'hDEADBEEF, 0);
        vecs[1]  = mk(0, 5'd0,  32'h0,        1, 5'd7, 32'h12345678, 1, 1, 5'd7,  32'h12345678, 1);
        vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 5'd0,  32'h0,        0);
        vecs[3]  = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,        0, 0, 5'd0,  32'h0,        0);
        vecs[4]  = mk(1, 5'd3,  32'hA5A5A5A5, 1, 5'd9, 32'h11111111, 0, 1, 5'd3,  32'hA5A5A5A5, 0);
        vecs[5]  = mk(0, 5'd0,  32'h0,        1, 5'd9, 32'h11111111, 1, 1, 5'd9,  32'h11111111, 1);
        vecs[6]  = mk(1, 5'd31, 32'h80000000, 0, 5'd0, 32'h0,        0, 1, 5'd31, 32'h80000000, 0);
        vecs[7]  = mk(1, 5'd1,  32'h00000001, 1, 5'd2, 32'hCAFEF00D, 0, 1, 5'd1,  32'h00000001, 0);
        vecs[8]  = mk(1, 5'd2,  32'h00000002, 1, 5'd2, 32'hCAFEF00D, 0, 1, 5'd2,  32'h00000002, 0);
        vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd2, 32'hCAFEF00D, 1, 1, 5'd2,  32'hCAFEF00D, 1);
        vecs[10] = mk(1, 5'd17, 32'h0F0F0F0F, 0, 5'd0, 32'h0,        0, 1, 5'd17, 32'h0F0F0F0F, 0);
        vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 5'd0,  32'h0,        0);

        // Reset state, with an LLU request present that must not be accepted.
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        llu_valid  = 1'b1; llu_rd  = 5'd4; llu_data = 32'h44444444;
        #1;
        chk_cleared("reset");
        @(posedge clk); #1;
        chk("reset_hold_rf_we", rf_we, 0);
        @(negedge clk);
        llu_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Pipe and LLU held valid together: starvation behaviour.
        for (int i = 0; i < 8; i++) begin
`ifdef WB_ARB_STARVE_EN
            fc = (i == LIM);
            v = mk(1, 5'd4, 32'h0000BEEF, (i <= LIM), 5'd6, 32'h66666666,
                   fc, 1, fc ? 5'd6 : 5'd4, fc ? 32'h66666666 : 32'h0000BEEF, fc);
`else
            fc = 1'b0;
            v = mk(1, 5'd4, 32'h0000BEEF, 1, 5'd6, 32'h66666666,
                   0, 1, 5'd4, 32'h0000BEEF, 0);
`endif
            cycle($sformatf("starve%0d", i), v, fc);
        end
        // Pipe drops: the still-pending LLU result is accepted (macro off),
        // or nothing is pending any more (macro on).
`ifdef WB_ARB_STARVE_EN
        cycle("starve_end", mk(0, 5'd0, 32'h0, 0, 5'd6, 32'h66666666, 0, 0, 5'd0, 32'h0, 0), 1'b0);
`else
        cycle("starve_end", mk(0, 5'd0, 32'h0, 1, 5'd6, 32'h66666666, 1, 1, 5'd6, 32'h66666666, 1), 1'b0);
`endif

        // Reset arriving while an LLU grant is being offered.
`ifdef WB_ARB_STARVE_EN
        for (int i = 0; i < LIM; i++) begin
            cycle($sformatf("rst_pre%0d", i),
                  mk(1, 5'd10, 32'h10101010, 1, 5'd11, 32'hBBBBBBBB, 0, 1, 5'd10, 32'h10101010, 0), 1'b0);
        end
        @(negedge clk); #1;
        chk("rst_force_stall", pipe_stall, 1);
        chk("rst_force_ready", llu_ready, 1);
`else
        cycle("rst_pre", mk(1, 5'd12, 32'h5555AAAA, 0, 5'd0, 32'h0, 0, 1, 5'd12, 32'h5555AAAA, 0), 1'b0);
        @(negedge clk);
        pipe_valid = 1'b0;
        llu_valid = 1'b1; llu_rd = 5'd11; llu_data = 32'hBBBBBBBB;
        #1;
        chk("rst_pre_ready", llu_ready, 1);
`endif
        rst = 1'b1;
        #1;
        chk_cleared("rst_async");
        @(posedge clk); #1;
        chk("rst_no_write_we", rf_we, 0);
        chk("rst_no_write_gnt", grant_llu, 0);
        @(negedge clk);
        rst = 1'b0;
        // Back in NORMAL with a clear counter: pipe wins, LLU waits.
        cycle("rst_after_pipe",
              mk(1, 5'd13, 32'h13131313, 1, 5'd11, 32'hBBBBBBBB, 0, 1, 5'd13, 32'h13131313, 0), 1'b0);
        cycle("rst_after_llu",
              mk(0, 5'd0, 32'h0, 1, 5'd11, 32'hBBBBBBBB, 1, 1, 5'd11, 32'hBBBBBBBB, 1), 1'b0);
        cycle("idle_end", mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0), 1'b0);

        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_wb_port_arbiter

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum number of cycles a long-latency-unit (LLU) request waits before the pipe is stalled; legal range 1..15.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 pipe_valid  in  1  MEM/WB stage has a write-back result this cycle.
REQ-008 pipe_rd  in  ADDR_WIDTH  pipe destination register.
REQ-009 pipe_data  in  DATA_WIDTH  pipe write-back value (already muxed by the writeback stage).
REQ-010 pipe_stall  out  1  freeze the pipe; MEM/WB holds pipe_valid/rd/data stable while this is high.
REQ-011 llu_valid  in  1  LLU (mul/div) result pending; held stable until accepted.
REQ-012 llu_rd  in  ADDR_WIDTH  LLU destination register.
REQ-013 llu_data  in  DATA_WIDTH  LLU result.
REQ-014 llu_ready  out  1  LLU result accepted this cycle (handshake = llu_valid && llu_ready).
REQ-015 rf_we  out  1  register-file write enable (registered).
REQ-016 rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
REQ-017 rf_wdata  out  DATA_WIDTH  register-file write data (registered).
REQ-018 grant_llu  out  1  registered; 1 when the current rf_* write came from the LLU.

Function
REQ-019 SHALL implement a two-state FSM: NORMAL and FORCE_LLU.
REQ-020 In NORMAL, the pipe SHALL have priority: pipe_valid grants the pipe; otherwise llu_valid grants the LLU; pipe_stall=0.
REQ-021 llu_ready SHALL be combinational and high exactly when the LLU is granted this cycle.
REQ-022 The granted request SHALL appear on rf_we/rf_waddr/rf_wdata/grant_llu on the next rising edge (latency 1); with no grant, rf_we=0 on the next edge.
REQ-023 A granted request with rd==0 SHALL complete its handshake but drive rf_we=0.
REQ-024 A starve counter SHALL increment on each cycle with llu_valid && !llu_ready, saturate at STARVE_LIMIT, and clear on an LLU handshake or when llu_valid is low.
REQ-025 NORMAL SHALL transition to FORCE_LLU on the edge where the counter reaches STARVE_LIMIT.
REQ-026 In FORCE_LLU, pipe_stall=1 combinationally, and the LLU SHALL be granted if llu_valid is high.
REQ-027 FORCE_LLU SHALL return to NORMAL on the edge after the LLU handshake, or immediately if llu_valid is low (protocol violation, no write).
REQ-028 A pipe request present during FORCE_LLU SHALL NOT be lost; it is granted in the first NORMAL cycle.
REQ-029 Same-rd conflicts between pipe and LLU SHALL be resolved only by grant order; hazard ordering is the hazard unit's responsibility.

Reset
REQ-030 On rst, the block SHALL set state=NORMAL, counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant_llu=0 asynchronously.
REQ-031 Reset asserted during FORCE_LLU SHALL abort the grant with no rf write; pipe_stall and llu_ready SHALL be 0 while rst is high.

Configuration
REQ-032 Macro WB_ARB_STARVE_EN, when defined, SHALL compile in the starve counter and the FORCE_LLU state per REQ-024..REQ-028.
REQ-033 Without WB_ARB_STARVE_EN, the block SHALL use strict pipe priority: pipe_stall is tied to 0, there is no counter, and the FSM stays in NORMAL.

Structure
REQ-034 The FSM state enum and the default DATA_WIDTH/ADDR_WIDTH constants SHALL live in the shared core package.
REQ-035 The block SHALL be a single module with no sub-modules; the starve counter is inline.

Verification
REQ-036 pipe_valid=1, rd=5, data=0xDEADBEEF, llu idle -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, grant_llu=0.
REQ-037 llu_valid=1, rd=7, data=0x12345678, pipe idle -> llu_ready=1 same cycle; next cycle rf_we=1, waddr=7, grant_llu=1.
REQ-038 pipe_valid held 1 and llu_valid=1 with STARVE_LIMIT=4 (macro on) -> llu_ready=0 for 4 cycles, then pipe_stall=1 and llu_ready=1 in cycle 5, then pipe resumes.
REQ-039 Same stimulus as REQ-038 with macro off -> llu_ready stays 0 and pipe_stall stays 0 while pipe_valid=1.
REQ-040 pipe_valid=1, rd=0, data=0xFFFFFFFF -> handshake completes, rf_we=0 next cycle.
REQ-041 rst pulsed while in FORCE_LLU -> all rf_* outputs are 0, pipe_stall=0, no write occurs, and the FSM is in NORMAL after release.
